// File: rtl/data_sram_resp_if.sv
// Data SRAM bus between the EXE-stage requester and the responder.
// Request fields are driven by the master, responses and counters by the slave.
interface data_sram_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        rdata_valid;
    logic        addr_err;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    modport master (
        output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata, rdata_valid, addr_err, rd_cnt, wr_cnt
    );

    modport slave (
        input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
        output data_sram_rdata, rdata_valid, addr_err, rd_cnt, wr_cnt
    );
endinterface

// File: rtl/data_sram_resp.sv
// Single-port data SRAM responder: zero-latency byte-strobed writes,
// one-cycle registered reads, range check against BASE, access counters.
module data_sram_resp #(
    parameter int          ADDR_W = 16,
    parameter logic [31:0] BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    data_sram_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [31:0]       r_mem [0:DEPTH-1];
    logic [31:0]       r_rdata;
    logic              r_rdata_valid;
    logic              r_addr_err;
    logic [31:0]       r_rd_cnt;
    logic [31:0]       r_wr_cnt;

    logic [31:0]       w_off;
    logic [ADDR_W-1:0] w_idx;
    logic              w_in_range;
    logic              w_is_wr;
    logic              w_is_rd;
    logic              w_unused;

    assign w_off      = bus.data_sram_addr - BASE;
    assign w_idx      = w_off[ADDR_W+1:2];
    assign w_in_range = (w_off[31:ADDR_W+2] == '0);
    assign w_is_wr    = bus.data_sram_en && (bus.data_sram_we != 4'b0000);
    assign w_is_rd    = bus.data_sram_en && (bus.data_sram_we == 4'b0000);
    // Byte placement comes from the strobes, so the low offset bits carry no information.
    assign w_unused   = ^w_off[1:0];

    // Storage is deliberately not reset; only the write path is gated by reset.
    always_ff @(posedge clk) begin
        if (!reset && w_is_wr && w_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.data_sram_we[i]) begin
                    r_mem[w_idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // Reading r_mem here sees the pre-edge contents, which gives read-first ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata       <= 32'h0;
            r_rdata_valid <= 1'b0;
            r_addr_err    <= 1'b0;
            r_rd_cnt      <= 32'h0;
            r_wr_cnt      <= 32'h0;
        end else begin
            r_rdata_valid <= w_is_rd;
            r_addr_err    <= bus.data_sram_en && !w_in_range;
            if (w_is_rd) begin
                if (w_in_range) begin
                    r_rdata  <= r_mem[w_idx];
                    r_rd_cnt <= r_rd_cnt + 32'd1;
                end else begin
                    r_rdata  <= 32'h0;
                end
            end
            if (w_is_wr && w_in_range) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end
        end
    end

    assign bus.data_sram_rdata = r_rdata;
    assign bus.rdata_valid     = r_rdata_valid;
    assign bus.addr_err        = r_addr_err;
    assign bus.rd_cnt          = r_rd_cnt;
    assign bus.wr_cnt          = r_wr_cnt;
endmodule
